// File: rtl/gp_register_bank.sv
// ---------------------------------------------------------------------------
// gp_register_bank
//   Parametrised general-purpose register bank (NREG x WIDTH) with two
//   combinational read ports (bus, ALU), one bus write port, addressed clear
//   and increment, and a tracked memory-load engine (IDLE/WAIT) with timeout.
//
// Optional feature macro: REGBANK_LD_BYPASS_EN
//   Defined   : on the completing cycle, a read port addressing the load
//               destination sees DIN directly and STALL is dropped.
//   Undefined : read ports always return stored values; STALL stays high
//               through the completion cycle.
//
// Ports
//   clk              clock, all state updates on rising edge
//   RST              synchronous active-high reset
//   WEN/WADDR/BIN    bus write port
//   CLREN/CLRADDR    clear addressed register
//   INCEN/INCADDR    increment addressed register (wraps)
//   RADDR/REGOUT     bus read port (combinational)
//   ALUADDR/ALUOUT   ALU read port (combinational)
//   MEMREAD/BOUT     BOUT = MEMREAD ? DIN : REGOUT
//   LDREQ/LDADDR     memory-load request and destination
//   DIN/MEMVALID     memory data and its valid strobe
//   LDACK            one-cycle pulse, load accepted
//   LDBUSY           load pending
//   LDERR            one-cycle pulse, load timed out
//   STALL            a read port addresses the pending destination
// ---------------------------------------------------------------------------
module gp_register_bank #(
    parameter int              WIDTH      = 16,
    parameter int              NREG       = 8,
    parameter int              AW         = $clog2(NREG),
    parameter logic [WIDTH-1:0] RST_VAL   = '0,
    parameter int              LD_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             WEN,
    input  logic [AW-1:0]    WADDR,
    input  logic [WIDTH-1:0] BIN,
    input  logic             CLREN,
    input  logic [AW-1:0]    CLRADDR,
    input  logic             INCEN,
    input  logic [AW-1:0]    INCADDR,
    input  logic [AW-1:0]    RADDR,
    output logic [WIDTH-1:0] REGOUT,
    input  logic [AW-1:0]    ALUADDR,
    output logic [WIDTH-1:0] ALUOUT,
    input  logic             MEMREAD,
    output logic [WIDTH-1:0] BOUT,
    input  logic             LDREQ,
    input  logic [AW-1:0]    LDADDR,
    input  logic [WIDTH-1:0] DIN,
    input  logic             MEMVALID,
    output logic             LDACK,
    output logic             LDBUSY,
    output logic             LDERR,
    output logic             STALL
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Counter only has to reach LD_TIMEOUT-1.
    localparam int             CW       = (LD_TIMEOUT < 2) ? 1 : $clog2(LD_TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(LD_TIMEOUT - 1);
    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] regs_r [NREG];
    logic [0:0]       state_r;
    logic [AW-1:0]    dest_r;
    logic [CW-1:0]    cnt_r;
    logic             ldack_r;
    logic             lderr_r;

    logic             ld_accept_s;
    logic             ld_done_s;
    logic             ld_abort_s;
    logic             byp_rd_s;
    logic             byp_alu_s;
    logic             stall_s;
    logic [WIDTH-1:0] rd_s;
    logic [WIDTH-1:0] alu_s;

    // Load engine event decode.
    always_comb begin
        ld_accept_s = 1'b0;
        ld_done_s   = 1'b0;
        ld_abort_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ld_accept_s = LDREQ;
            end
            ST_WAIT: begin
                if (MEMVALID) begin
                    ld_done_s = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    ld_abort_s = 1'b1;
                end else begin
                    ld_done_s = 1'b0;
                end
            end
            default: begin
                ld_accept_s = 1'b0;
            end
        endcase
    end

    // Register array update; load completion outranks clear, write, increment.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (RST) begin
                regs_r[i] <= RST_VAL;
            end else if (ld_done_s && (dest_r == AW'(i))) begin
                regs_r[i] <= DIN;
            end else if (CLREN && (CLRADDR == AW'(i))) begin
                regs_r[i] <= '0;
            end else if (WEN && (WADDR == AW'(i))) begin
                regs_r[i] <= BIN;
            end else if (INCEN && (INCADDR == AW'(i))) begin
                regs_r[i] <= regs_r[i] + ONE;
            end else begin
                regs_r[i] <= regs_r[i];
            end
        end
    end

    // Load FSM, destination latch, timeout counter and status pulses.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_r <= ST_IDLE;
            dest_r  <= '0;
            cnt_r   <= '0;
            ldack_r <= 1'b0;
            lderr_r <= 1'b0;
        end else begin
            ldack_r <= ld_accept_s;
            lderr_r <= ld_abort_s;
            case (state_r)
                ST_IDLE: begin
                    if (ld_accept_s) begin
                        state_r <= ST_WAIT;
                        dest_r  <= LDADDR;
                        cnt_r   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (ld_done_s || ld_abort_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Read muxes; out-of-range addresses match no entry and read as zero.
    always_comb begin
        rd_s  = '0;
        alu_s = '0;
        for (int i = 0; i < NREG; i++) begin
            if (RADDR == AW'(i)) begin
                rd_s = regs_r[i];
            end else begin
                rd_s = rd_s;
            end
            if (ALUADDR == AW'(i)) begin
                alu_s = regs_r[i];
            end else begin
                alu_s = alu_s;
            end
        end
    end

`ifdef REGBANK_LD_BYPASS_EN
    // Forward DIN to ports addressing the destination on the completing cycle.
    always_comb begin
        byp_rd_s  = ld_done_s && (RADDR == dest_r);
        byp_alu_s = ld_done_s && (ALUADDR == dest_r);
        if (ld_done_s) begin
            stall_s = 1'b0;
        end else begin
            stall_s = (state_r == ST_WAIT) && ((RADDR == dest_r) || (ALUADDR == dest_r));
        end
    end
`else
    // No forwarding: stored values only, stall held through completion.
    always_comb begin
        byp_rd_s  = 1'b0;
        byp_alu_s = 1'b0;
        stall_s   = (state_r == ST_WAIT) && ((RADDR == dest_r) || (ALUADDR == dest_r));
    end
`endif

    assign REGOUT = byp_rd_s  ? DIN : rd_s;
    assign ALUOUT = byp_alu_s ? DIN : alu_s;
    assign BOUT   = MEMREAD   ? DIN : REGOUT;
    assign LDACK  = ldack_r;
    assign LDERR  = lderr_r;
    assign LDBUSY = (state_r == ST_WAIT);
    assign STALL  = stall_s;

endmodule

// File: tb/tb_gp_register_bank.sv
// ---------------------------------------------------------------------------
// tb_gp_register_bank
//   Directed, self-checking bench for gp_register_bank at default parameters
//   (WIDTH=16, NREG=8, LD_TIMEOUT=15, RST_VAL=0). Follows the same
//   REGBANK_LD_BYPASS_EN macro as the design for bypass expectations.
// ---------------------------------------------------------------------------
module tb_gp_register_bank;

    logic        clk;
    logic        RST;
    logic        WEN;
    logic [2:0]  WADDR;
    logic [15:0] BIN;
    logic        CLREN;
    logic [2:0]  CLRADDR;
    logic        INCEN;
    logic [2:0]  INCADDR;
    logic [2:0]  RADDR;
    logic [15:0] REGOUT;
    logic [2:0]  ALUADDR;
    logic [15:0] ALUOUT;
    logic        MEMREAD;
    logic [15:0] BOUT;
    logic        LDREQ;
    logic [2:0]  LDADDR;
    logic [15:0] DIN;
    logic        MEMVALID;
    logic        LDACK;
    logic        LDBUSY;
    logic        LDERR;
    logic        STALL;

    int pass_cnt  = 0;
    int total_cnt = 0;

    gp_register_bank dut (
        .clk(clk), .RST(RST),
        .WEN(WEN), .WADDR(WADDR), .BIN(BIN),
        .CLREN(CLREN), .CLRADDR(CLRADDR),
        .INCEN(INCEN), .INCADDR(INCADDR),
        .RADDR(RADDR), .REGOUT(REGOUT),
        .ALUADDR(ALUADDR), .ALUOUT(ALUOUT),
        .MEMREAD(MEMREAD), .BOUT(BOUT),
        .LDREQ(LDREQ), .LDADDR(LDADDR), .DIN(DIN), .MEMVALID(MEMVALID),
        .LDACK(LDACK), .LDBUSY(LDBUSY), .LDERR(LDERR), .STALL(STALL)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        WEN = 1'b0; WADDR = 3'd0; BIN = 16'h0000;
        CLREN = 1'b0; CLRADDR = 3'd0; INCEN = 1'b0; INCADDR = 3'd0;
        RADDR = 3'd0; ALUADDR = 3'd0; MEMREAD = 1'b0;
        LDREQ = 1'b0; LDADDR = 3'd0; DIN = 16'h0000; MEMVALID = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step(); step();
        RST = 1'b0;
        #1;
        total_cnt++;
        if ({LDACK, LDBUSY, LDERR, STALL} !== 4'b0000) $display("FAIL reset_flags: got %b expected 0000", {LDACK, LDBUSY, LDERR, STALL});
        else pass_cnt++;
        for (int a = 0; a < 8; a++) begin
            RADDR = 3'(a); ALUADDR = 3'(7 - a);
            #1;
            total_cnt++;
            if (REGOUT !== 16'h0000 || ALUOUT !== 16'h0000) $display("FAIL reset_reg%0d: got %h/%h expected 0000/0000", a, REGOUT, ALUOUT);
            else pass_cnt++;
        end
    endtask

    task automatic test_write_read();
        WEN = 1'b1; WADDR = 3'd3; BIN = 16'h1234;
        step();
        WEN = 1'b0; RADDR = 3'd3; ALUADDR = 3'd3;
        #1;
        total_cnt++;
        if (REGOUT !== 16'h1234) $display("FAIL wr_regout: got %h expected 1234", REGOUT);
        else pass_cnt++;
        total_cnt++;
        if (ALUOUT !== 16'h1234) $display("FAIL wr_aluout: got %h expected 1234", ALUOUT);
        else pass_cnt++;
        RADDR = 3'd0;
        #1;
        total_cnt++;
        if (REGOUT !== 16'h0000 || BOUT !== 16'h0000) $display("FAIL rd_r0: got %h bout %h expected 0000", REGOUT, BOUT);
        else pass_cnt++;
        MEMREAD = 1'b1; DIN = 16'h7777;
        #1;
        total_cnt++;
        if (BOUT !== 16'h7777) $display("FAIL bout_din: got %h expected 7777", BOUT);
        else pass_cnt++;
        MEMREAD = 1'b0; DIN = 16'h0000;
    endtask

    task automatic test_increment();
        WEN = 1'b1; WADDR = 3'd5; BIN = 16'hFFFF;
        step();
        WEN = 1'b0; INCEN = 1'b1; INCADDR = 3'd5;
        step();
        INCEN = 1'b0; RADDR = 3'd5;
        #1;
        total_cnt++;
        if (REGOUT !== 16'h0000) $display("FAIL inc_wrap: got %h expected 0000", REGOUT);
        else pass_cnt++;
        INCEN = 1'b1;
        step();
        INCEN = 1'b0;
        #1;
        total_cnt++;
        if (REGOUT !== 16'h0001) $display("FAIL inc_one: got %h expected 0001", REGOUT);
        else pass_cnt++;
    endtask

    task automatic test_priority();
        WEN = 1'b1; WADDR = 3'd2; BIN = 16'h1111;
        step();
        CLREN = 1'b1; CLRADDR = 3'd2; BIN = 16'hAAAA; INCEN = 1'b1; INCADDR = 3'd2;
        step();
        CLREN = 1'b0; INCEN = 1'b0; WEN = 1'b0; RADDR = 3'd2;
        #1;
        total_cnt++;
        if (REGOUT !== 16'h0000) $display("FAIL prio_clr: got %h expected 0000", REGOUT);
        else pass_cnt++;
        WEN = 1'b1; WADDR = 3'd2; BIN = 16'h0010; INCEN = 1'b1; INCADDR = 3'd2;
        step();
        WEN = 1'b0; INCEN = 1'b0;
        #1;
        total_cnt++;
        if (REGOUT !== 16'h0010) $display("FAIL prio_wen: got %h expected 0010", REGOUT);
        else pass_cnt++;
        // Different registers in one edge: clear R3, write R7, increment R5 (1 -> 2).
        CLREN = 1'b1; CLRADDR = 3'd3; WEN = 1'b1; WADDR = 3'd7; BIN = 16'h00A5;
        INCEN = 1'b1; INCADDR = 3'd5;
        step();
        CLREN = 1'b0; WEN = 1'b0; INCEN = 1'b0;
        RADDR = 3'd3; ALUADDR = 3'd7;
        #1;
        total_cnt++;
        if (REGOUT !== 16'h0000 || ALUOUT !== 16'h00A5) $display("FAIL multi_r3r7: got %h/%h expected 0000/00a5", REGOUT, ALUOUT);
        else pass_cnt++;
        RADDR = 3'd5;
        #1;
        total_cnt++;
        if (REGOUT !== 16'h0002) $display("FAIL multi_r5: got %h expected 0002", REGOUT);
        else pass_cnt++;
    endtask

    task automatic test_load();
        RADDR = 3'd6; ALUADDR = 3'd0;
        LDREQ = 1'b1; LDADDR = 3'd6;
        step();
        LDREQ = 1'b0;
        // WAIT cycle 1
        total_cnt++;
        if ({LDACK, LDBUSY, STALL} !== 3'b111) $display("FAIL ld_c1: got ack/busy/stall %b expected 111", {LDACK, LDBUSY, STALL});
        else pass_cnt++;
        // Second request in WAIT is ignored; bus write to dest is performed.
        LDREQ = 1'b1; LDADDR = 3'd0; WEN = 1'b1; WADDR = 3'd6; BIN = 16'h1234;
        step();
        // WAIT cycle 2
        LDREQ = 1'b0; WEN = 1'b0;
        #1;
        total_cnt++;
        if ({LDACK, LDBUSY, STALL} !== 3'b011) $display("FAIL ld_c2: got ack/busy/stall %b expected 011", {LDACK, LDBUSY, STALL});
        else pass_cnt++;
        step();
        // WAIT cycle 3: data arrives together with a competing write to dest.
        total_cnt++;
        if ({LDACK, LDBUSY} !== 2'b01) $display("FAIL ld_c3_ack: got ack/busy %b expected 01", {LDACK, LDBUSY});
        else pass_cnt++;
        MEMVALID = 1'b1; DIN = 16'hBEEF; WEN = 1'b1; WADDR = 3'd6; BIN = 16'h5555;
        #1;
`ifdef REGBANK_LD_BYPASS_EN
        total_cnt++;
        if (STALL !== 1'b0 || REGOUT !== 16'hBEEF) $display("FAIL ld_c3_byp: got stall %b regout %h expected 0 beef", STALL, REGOUT);
        else pass_cnt++;
`else
        total_cnt++;
        if (STALL !== 1'b1 || REGOUT !== 16'h1234) $display("FAIL ld_c3_nobyp: got stall %b regout %h expected 1 1234", STALL, REGOUT);
        else pass_cnt++;
`endif
        step();
        MEMVALID = 1'b0; WEN = 1'b0; DIN = 16'h0000;
        #1;
        total_cnt++;
        if ({LDACK, LDBUSY, LDERR, STALL} !== 4'b0000) $display("FAIL ld_done_flags: got %b expected 0000", {LDACK, LDBUSY, LDERR, STALL});
        else pass_cnt++;
        total_cnt++;
        if (REGOUT !== 16'hBEEF) $display("FAIL ld_data: got %h expected beef", REGOUT);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        RADDR = 3'd0; ALUADDR = 3'd1;
        LDREQ = 1'b1; LDADDR = 3'd0;
        step();
        // First WAIT cycle: complete immediately, request held for R1.
        LDADDR = 3'd1; MEMVALID = 1'b1; DIN = 16'h0101;
        step();
        MEMVALID = 1'b0;
        #1;
        total_cnt++;
        if ({LDACK, LDBUSY} !== 2'b00) $display("FAIL b2b_gap: got ack/busy %b expected 00", {LDACK, LDBUSY});
        else pass_cnt++;
        step();
        LDREQ = 1'b0; MEMVALID = 1'b1; DIN = 16'h0202;
        #1;
        total_cnt++;
        if ({LDACK, LDBUSY} !== 2'b11) $display("FAIL b2b_ack2: got ack/busy %b expected 11", {LDACK, LDBUSY});
        else pass_cnt++;
        step();
        MEMVALID = 1'b0; DIN = 16'h0000;
        #1;
        total_cnt++;
        if (REGOUT !== 16'h0101 || ALUOUT !== 16'h0202) $display("FAIL b2b_data: got %h/%h expected 0101/0202", REGOUT, ALUOUT);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int cyc;
        bit busy_ok;
        RADDR = 3'd1; ALUADDR = 3'd0;
        LDREQ = 1'b1; LDADDR = 3'd1;
        step();
        LDREQ = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (LDERR !== 1'b1 && cyc < 40) begin
            if (LDBUSY !== 1'b1) busy_ok = 1'b0;
            step();
            cyc++;
        end
        total_cnt++;
        if (cyc != 16) $display("FAIL to_latency: got lderr in cycle %0d expected 16", cyc);
        else pass_cnt++;
        total_cnt++;
        if (!busy_ok || LDBUSY !== 1'b0) $display("FAIL to_busy: got busy_ok %0d busy %b expected 1 0", busy_ok, LDBUSY);
        else pass_cnt++;
        step();
        total_cnt++;
        if (LDERR !== 1'b0 || REGOUT !== 16'h0202) $display("FAIL to_after: got lderr %b r1 %h expected 0 0202", LDERR, REGOUT);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        RADDR = 3'd4; ALUADDR = 3'd0;
        LDREQ = 1'b1; LDADDR = 3'd4;
        step();
        LDREQ = 1'b0; MEMVALID = 1'b1; DIN = 16'h5A5A;
        #1;
`ifdef REGBANK_LD_BYPASS_EN
        total_cnt++;
        if (REGOUT !== 16'h5A5A || STALL !== 1'b0) $display("FAIL byp_same: got %h stall %b expected 5a5a 0", REGOUT, STALL);
        else pass_cnt++;
`else
        total_cnt++;
        if (REGOUT !== 16'h0000 || STALL !== 1'b1) $display("FAIL byp_off: got %h stall %b expected 0000 1", REGOUT, STALL);
        else pass_cnt++;
`endif
        step();
        MEMVALID = 1'b0; DIN = 16'h0000;
        #1;
        total_cnt++;
        if (REGOUT !== 16'h5A5A || STALL !== 1'b0) $display("FAIL byp_next: got %h stall %b expected 5a5a 0", REGOUT, STALL);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_wait();
        bit err_seen;
        RADDR = 3'd7; ALUADDR = 3'd4;
        LDREQ = 1'b1; LDADDR = 3'd7;
        step();
        LDREQ = 1'b0;
        step();
        // Second WAIT cycle
        RST = 1'b1;
        step();
        RST = 1'b0;
        #1;
        total_cnt++;
        if ({LDBUSY, STALL} !== 2'b00 || REGOUT !== 16'h0000 || ALUOUT !== 16'h0000) $display("FAIL rstw_state: got busy/stall %b regs %h/%h expected 00 0000/0000", {LDBUSY, STALL}, REGOUT, ALUOUT);
        else pass_cnt++;
        MEMVALID = 1'b1; DIN = 16'hDEAD;
        step();
        MEMVALID = 1'b0;
        err_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (LDERR !== 1'b0 || LDACK !== 1'b0) err_seen = 1'b1;
            step();
        end
        total_cnt++;
        if (REGOUT !== 16'h0000 || err_seen) $display("FAIL rstw_after: got r7 %h pulse_seen %0d expected 0000 0", REGOUT, err_seen);
        else pass_cnt++;
    endtask

    initial begin
        RST = 1'b1;
        idle_inputs();
        test_reset();
        test_write_read();
        idle_inputs();
        test_increment();
        idle_inputs();
        test_priority();
        idle_inputs();
        test_load();
        idle_inputs();
        test_back_to_back();
        idle_inputs();
        test_timeout();
        idle_inputs();
        test_bypass();
        idle_inputs();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/gp_register_bank.md
# gp_register_bank

Parametrised general-purpose register bank for the multicore datapath, replacing fixed per-register instances with one addressed array. It has two combinational read ports (bus and ALU), one bus write port, and addressed clear and increment. A tracked memory-load engine fills a destination register when memory data arrives. The engine stalls reads of that register while the load is pending and aborts the load on timeout.

## Interface
- WIDTH, 16, data width of every register
- NREG, 8, number of registers (2..32)
- AW, $clog2(NREG), address width
- RST_VAL, 0, reset value of every register
- LD_TIMEOUT, 15, maximum WAIT cycles before a load aborts (≥1)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- WEN  in  1  write enable, bus write port
- WADDR  in  AW  write address
- BIN  in  WIDTH  bus write data
- CLREN / CLRADDR  in  1 / AW  clear addressed register to 0
- INCEN / INCADDR  in  1 / AW  increment addressed register
- RADDR  in  AW  bus read address
- REGOUT  out  WIDTH  bus read data
- ALUADDR  in  AW  ALU read address
- ALUOUT  out  WIDTH  ALU read data
- MEMREAD  in  1  BOUT source select
- BOUT  out  WIDTH  MEMREAD ? DIN : REGOUT
- LDREQ / LDADDR  in  1 / AW  memory-load request and destination
- DIN  in  WIDTH  memory data
- MEMVALID  in  1  DIN valid strobe
- LDACK  out  1  one-cycle pulse, load accepted
- LDBUSY  out  1  load pending
- LDERR  out  1  one-cycle pulse, load timed out
- STALL  out  1  read port addresses a pending destination

## Operation
- Register array: NREG × WIDTH.
- REGOUT and ALUOUT are combinational reads of reg[RADDR] and reg[ALUADDR].
- Address ≥ NREG: writes, clears and increments are ignored; reads return 0.
- Increment wraps modulo 2^WIDTH (0xFFFF → 0x0000 at WIDTH=16).
- Events on different registers in the same edge all take effect.
- Same-register priority: load completion > CLREN > WEN > INCEN. The losing operations are dropped.
- Load FSM states: IDLE, WAIT.
  - IDLE: LDREQ=1 latches LDADDR into dest, clears the timeout counter and moves to WAIT.
  - WAIT, MEMVALID=1: write DIN into reg[dest] and return to IDLE.
  - WAIT, MEMVALID=0 with counter = LD_TIMEOUT−1: abort with no write and return to IDLE.
  - WAIT otherwise: increment the counter.
  - LDREQ in WAIT is ignored; no LDACK is issued.
- MEMVALID in IDLE is ignored.
- LDREQ with out-of-range LDADDR is accepted. Completion writes nothing.
- LDBUSY = (state == WAIT).
- STALL = LDBUSY && (RADDR == dest || ALUADDR == dest).
- Bus writes, clears and increments to dest during WAIT are performed. A completed load overwrites them.
- Reset values:
  - all registers = RST_VAL
  - FSM = IDLE, counter = 0
  - LDACK, LDBUSY, LDERR, STALL = 0
  - REGOUT, ALUOUT = RST_VAL
- RST during WAIT aborts the load: no write, no LDERR.

## Timing
- Read latency: 0 cycles (combinational).
- Write, clear and increment are visible on the read ports the cycle after the edge.
- LDACK and LDBUSY rise the cycle after the accepting edge.
- Earliest completion: MEMVALID in the first WAIT cycle, so a back-to-back load is accepted 2 cycles after the first.
- Loaded data is visible the cycle after the MEMVALID edge.
- MEMVALID is honoured in any of the first LD_TIMEOUT WAIT cycles. If absent from all of them, LDERR pulses in the cycle after the aborting edge and LDBUSY falls at the same time.

## Configuration
- REGBANK_LD_BYPASS_EN defined:
  - In WAIT with MEMVALID=1, a read port whose address equals dest returns DIN in that same cycle.
  - STALL is 0 in that cycle.
- Not defined:
  - Read ports return the stored value.
  - STALL stays high through the completion cycle.
  - Data is readable from the next cycle.

## Test plan
- Reset, then WEN to R3 with BIN=0x1234; next cycle set RADDR=3 and ALUADDR=3 → both outputs read 0x1234, and a read of R0 returns 0x0000.
- R5=0xFFFF, INCEN to R5 → R5=0x0000. In one edge, apply CLREN, WEN (0xAAAA) and INCEN all to R2 → R2=0x0000.
- LDREQ to R6, MEMVALID with DIN=0xBEEF on the 3rd WAIT cycle:
  - LDACK pulses once.
  - LDBUSY is high for 3 cycles.
  - STALL is high while RADDR=6.
  - R6 reads 0xBEEF afterwards.
- LDREQ to R1 with no MEMVALID, LD_TIMEOUT=15 → LDERR pulses 16 cycles after the request edge, and R1 is unchanged.
- Bypass: LDREQ to R4, then MEMVALID with DIN=0x5A5A and RADDR=4.
  - With REGBANK_LD_BYPASS_EN: REGOUT=0x5A5A and STALL=0 in the same cycle.
  - Without it: STALL=1 in that cycle.
- RST asserted in the 2nd WAIT cycle → LDBUSY=0 and registers at RST_VAL; a later MEMVALID causes no write, and no LDERR pulse occurs.
